// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit.
package lsu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_MERGE = 2'd2;

    function automatic int clogb2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Big-endian byte-lane extract/extend, sub-word merge and alignment check.
module load_store_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    input  logic [31:0] mem_word,
    input  logic [31:0] wdata,
    output logic        misaligned,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        case (size)
            SIZE_BYTE: misaligned = 1'b0;
            SIZE_HALF: misaligned = offset[0];
            SIZE_WORD: misaligned = (offset != 2'b00);
            default:   misaligned = 1'b1;
        endcase
    end

    always_comb begin
        case (offset)
            2'd0:    lane_b = mem_word[31:24];
            2'd1:    lane_b = mem_word[23:16];
            2'd2:    lane_b = mem_word[15:8];
            default: lane_b = mem_word[7:0];
        endcase
        lane_h = offset[1] ? mem_word[15:0] : mem_word[31:16];
    end

    always_comb begin
        case (size)
            SIZE_BYTE: load_data = {{24{~is_unsigned & lane_b[7]}}, lane_b};
            SIZE_HALF: load_data = {{16{~is_unsigned & lane_h[15]}}, lane_h};
            default:   load_data = mem_word;
        endcase
    end

    always_comb begin
        merge_data = mem_word;
        case (size)
            SIZE_BYTE: begin
                case (offset)
                    2'd0:    merge_data[31:24] = wdata[7:0];
                    2'd1:    merge_data[23:16] = wdata[7:0];
                    2'd2:    merge_data[15:8]  = wdata[7:0];
                    default: merge_data[7:0]   = wdata[7:0];
                endcase
            end
            SIZE_HALF: begin
                if (offset[1]) merge_data[15:0]  = wdata[15:0];
                else           merge_data[31:16] = wdata[15:0];
            end
            default: merge_data = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage requester: word-wide memory access with sub-word loads and
// read-modify-write sub-word stores.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int RAM_WIDTH = 32,
    parameter int RAM_DEPTH = 1024,
    parameter int AW        = clogb2(RAM_DEPTH)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_req,
    input  logic                 i_we,
    input  logic [1:0]           i_size,
    input  logic                 i_unsigned,
    input  logic [31:0]          i_addr,
    input  logic [RAM_WIDTH-1:0] i_wdata,
    output logic                 o_ready,
    output logic                 o_done,
    output logic [RAM_WIDTH-1:0] o_rdata,
    output logic                 o_misaligned,
    output logic [AW-1:0]        o_mem_addr,
    output logic [RAM_WIDTH-1:0] o_mem_data,
    output logic                 o_mem_we,
    input  logic [RAM_WIDTH-1:0] i_mem_data
);

    logic [1:0]           state;
    logic [AW-1:0]        r_addr;
    logic [1:0]           r_off;
    logic [1:0]           r_size;
    logic                 r_uns;
    logic [RAM_WIDTH-1:0] r_wdata;

    logic                 idle;
    logic                 accept;
    logic                 store_word;
    logic [1:0]           a_size;
    logic [1:0]           a_off;
    logic                 a_uns;
    logic                 mis;
    logic [RAM_WIDTH-1:0] load_data;
    logic [RAM_WIDTH-1:0] merge_data;
    logic                 unused_addr_bits;

    assign unused_addr_bits = ^i_addr[31:AW+2];

    assign idle    = (state == ST_IDLE);
    assign o_ready = idle;
    assign accept  = i_req && idle;

    // Alignment check looks at the live request; extract/merge at the held one.
    assign a_size = idle ? i_size     : r_size;
    assign a_off  = idle ? i_addr[1:0] : r_off;
    assign a_uns  = idle ? i_unsigned : r_uns;

    load_store_align u_align (
        .size        (a_size),
        .offset      (a_off),
        .is_unsigned (a_uns),
        .mem_word    (i_mem_data),
        .wdata       (r_wdata),
        .misaligned  (mis),
        .load_data   (load_data),
        .merge_data  (merge_data)
    );

    assign store_word = accept && i_we && (i_size == SIZE_WORD) && !mis;

    always_comb begin
        o_mem_addr = r_addr;
        o_mem_data = r_wdata;
        if (accept) begin
            o_mem_addr = i_addr[AW+1:2];
            o_mem_data = i_wdata;
        end
        if (state == ST_MERGE) o_mem_data = merge_data;
    end

    assign o_mem_we = !i_reset && (store_word || state == ST_MERGE);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= ST_IDLE;
            o_done       <= 1'b0;
            o_rdata      <= '0;
            o_misaligned <= 1'b0;
            r_addr       <= '0;
            r_off        <= '0;
            r_size       <= '0;
            r_uns        <= 1'b0;
            r_wdata      <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        r_addr  <= i_addr[AW+1:2];
                        r_off   <= i_addr[1:0];
                        r_size  <= i_size;
                        r_uns   <= i_unsigned;
                        r_wdata <= i_wdata;
                        if (mis) begin
                            o_done       <= 1'b1;
                            o_misaligned <= 1'b1;
                            o_rdata      <= '0;
                        end else if (!i_we) begin
                            state <= ST_LOAD;
                        end else if (i_size == SIZE_WORD) begin
                            o_done       <= 1'b1;
                            o_misaligned <= 1'b0;
                        end else begin
                            state <= ST_MERGE;
                        end
                    end
                end
                ST_LOAD: begin
                    o_rdata      <= load_data;
                    o_done       <= 1'b1;
                    o_misaligned <= 1'b0;
                    state        <= ST_IDLE;
                end
                ST_MERGE: begin
                    o_done       <= 1'b1;
                    o_misaligned <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: directed vectors, reset corner cases and random
// traffic against a byte-array reference model with a behavioural memory.
module tb_load_store_unit;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          i_reset;
    logic          i_req;
    logic          i_we;
    logic [1:0]    i_size;
    logic          i_unsigned;
    logic [31:0]   i_addr;
    logic [31:0]   i_wdata;
    logic          o_ready;
    logic          o_done;
    logic [31:0]   o_rdata;
    logic          o_misaligned;
    logic [AW-1:0] o_mem_addr;
    logic [31:0]   o_mem_data;
    logic          o_mem_we;
    logic [31:0]   i_mem_data;

    always #5 clk = ~clk;

    load_store_unit dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_req        (i_req),
        .i_we         (i_we),
        .i_size       (i_size),
        .i_unsigned   (i_unsigned),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .o_ready      (o_ready),
        .o_done       (o_done),
        .o_rdata      (o_rdata),
        .o_misaligned (o_misaligned),
        .o_mem_addr   (o_mem_addr),
        .o_mem_data   (o_mem_data),
        .o_mem_we     (o_mem_we),
        .i_mem_data   (i_mem_data)
    );

    // Data memory: registered read, read register frozen during writes.
    logic [31:0] mem [DEPTH];
    logic [31:0] mem_rd;
    logic        tb_init;
    int          we_count = 0;

    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
            mem[4] <= 32'h8899AABB;
        end else if (o_mem_we) begin
            mem[o_mem_addr] <= o_mem_data;
        end else begin
            mem_rd <= mem[o_mem_addr];
        end
    end

    always @(posedge clk) if (o_mem_we) we_count <= we_count + 1;

    assign i_mem_data = mem_rd;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: 16 words viewed as a big-endian byte array.
    logic [31:0] shadow [16];

    function automatic logic [7:0] get_byte(input logic [31:0] w, input int i);
        logic [31:0] t;
        t = w >> (8 * (3 - i));
        return t[7:0];
    endfunction

    task automatic model(input logic we, input logic [1:0] sz, input logic un,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic mis);
        int wi, off, nb;
        longint v;
        logic [31:0] w, sh;
        wi  = int'(addr[5:2]);
        off = int'(addr[1:0]);
        nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
        rd  = 32'h0;
        mis = (nb == 0) || ((off % nb) != 0);
        if (mis) return;
        w = shadow[wi];
        if (we) begin
            for (int k = 0; k < nb; k++) begin
                sh = 32'(8 * (3 - (off + k)));
                w = (w & ~(32'hFF << sh)) |
                    (32'(get_byte(wd, 4 - nb + k)) << sh);
            end
            shadow[wi] = w;
        end else begin
            v = 0;
            for (int k = 0; k < nb; k++) v = v * 256 + longint'(get_byte(w, off + k));
            if (!un && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
                v = v - (longint'(1) << (8 * nb));
            rd = v[31:0];
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic un,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd,
                          output logic mis, output logic rdy1);
        @(negedge clk);
        i_req = 1'b1; i_we = we; i_size = sz; i_unsigned = un;
        i_addr = addr; i_wdata = wd;
        lat = 0; rd = 32'h0; mis = 1'b0; rdy1 = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            i_req = 1'b0;
            if (i == 1) rdy1 = o_ready;
            if (o_done) begin
                lat = i; rd = o_rdata; mis = o_misaligned;
                break;
            end
        end
    endtask

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_mis;
        logic [1:0]  exp_lat;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int lat, wc0;
        logic [31:0] rd, mrd;
        logic mis, mmis, rdy1;

        vecs[0]  = '{1'b0, 2'd0, 1'b0, 32'h11, 32'h0,        32'hFFFFFF99, 1'b0, 2'd2};
        vecs[1]  = '{1'b0, 2'd0, 1'b1, 32'h11, 32'h0,        32'h00000099, 1'b0, 2'd2};
        vecs[2]  = '{1'b0, 2'd1, 1'b0, 32'h12, 32'h0,        32'hFFFFAABB, 1'b0, 2'd2};
        vecs[3]  = '{1'b0, 2'd1, 1'b1, 32'h10, 32'h0,        32'h00008899, 1'b0, 2'd2};
        vecs[4]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h8899AABB, 1'b0, 2'd2};
        vecs[5]  = '{1'b1, 2'd0, 1'b0, 32'h13, 32'h000000CC, 32'h0,        1'b0, 2'd2};
        vecs[6]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h8899AACC, 1'b0, 2'd2};
        vecs[7]  = '{1'b0, 2'd1, 1'b0, 32'h11, 32'h0,        32'h0,        1'b1, 2'd1};
        vecs[8]  = '{1'b0, 2'd2, 1'b0, 32'h12, 32'h0,        32'h0,        1'b1, 2'd1};
        vecs[9]  = '{1'b0, 2'd3, 1'b0, 32'h10, 32'h0,        32'h0,        1'b1, 2'd1};
        vecs[10] = '{1'b1, 2'd1, 1'b0, 32'h11, 32'h5555,     32'h0,        1'b1, 2'd1};

        i_reset = 1'b1; tb_init = 1'b1; i_req = 1'b0; i_we = 1'b0;
        i_size = 2'd0; i_unsigned = 1'b0; i_addr = 32'h0; i_wdata = 32'h0;
        for (int i = 0; i < 16; i++) shadow[i] = 32'h0;
        shadow[4] = 32'h8899AABB;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tb_init = 1'b0;
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_rdata", o_rdata, 32'h0);
        check("rst_mis", 32'(o_misaligned), 32'd0);
        check("rst_we", 32'(o_mem_we), 32'd0);
        check("rst_addr", 32'(o_mem_addr), 32'd0);
        @(negedge clk);
        i_reset = 1'b0;

        // SH 0x10 aborted by reset in its MERGE cycle
        @(negedge clk);
        wc0 = we_count;
        i_req = 1'b1; i_we = 1'b1; i_size = 2'd1; i_unsigned = 1'b0;
        i_addr = 32'h10; i_wdata = 32'h00001234;
        @(negedge clk);
        i_req = 1'b0;
        check("merge_ready", 32'(o_ready), 32'd0);
        i_reset = 1'b1;
        #1;
        check("rstmerge_we", 32'(o_mem_we), 32'd0);
        @(negedge clk);
        i_reset = 1'b0;
        check("rstmerge_done", 32'(o_done), 32'd0);
        check("rstmerge_ready", 32'(o_ready), 32'd1);
        check("rstmerge_mem", mem[4], 32'h8899AABB);
        check("rstmerge_wcnt", 32'(we_count), 32'(wc0));

        for (int v = 0; v < 11; v++) begin
            model(vecs[v].we, vecs[v].size, vecs[v].uns, vecs[v].addr,
                  vecs[v].wdata, mrd, mmis);
            wc0 = we_count;
            do_req(vecs[v].we, vecs[v].size, vecs[v].uns, vecs[v].addr,
                   vecs[v].wdata, lat, rd, mis, rdy1);
            check($sformatf("vec%0d_lat", v), 32'(lat), 32'(vecs[v].exp_lat));
            check($sformatf("vec%0d_mis", v), 32'(mis), 32'(vecs[v].exp_mis));
            check($sformatf("vec%0d_rdy1", v), 32'(rdy1),
                  (vecs[v].exp_lat == 2'd2) ? 32'd0 : 32'd1);
            if (!vecs[v].we || vecs[v].exp_mis)
                check($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rd);
            if (vecs[v].exp_mis)
                check($sformatf("vec%0d_nowrite", v), 32'(we_count), 32'(wc0));
        end
        check("sb_mem4", mem[4], 32'h8899AACC);

        // Back-to-back SW
        model(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF, mrd, mmis);
        model(1'b1, 2'd2, 1'b0, 32'h24, 32'h01234567, mrd, mmis);
        @(negedge clk);
        i_req = 1'b1; i_we = 1'b1; i_size = 2'd2; i_addr = 32'h20;
        i_wdata = 32'hDEADBEEF;
        @(negedge clk);
        check("sw1_done", 32'(o_done), 32'd1);
        check("sw1_ready", 32'(o_ready), 32'd1);
        i_addr = 32'h24; i_wdata = 32'h01234567;
        @(negedge clk);
        i_req = 1'b0;
        check("sw2_done", 32'(o_done), 32'd1);
        check("sw2_ready", 32'(o_ready), 32'd1);
        @(negedge clk);
        check("sw_idle_done", 32'(o_done), 32'd0);
        check("sw1_mem", mem[8], 32'hDEADBEEF);
        check("sw2_mem", mem[9], 32'h01234567);

        for (int n = 0; n < 300; n++) begin
            logic        rwe, run;
            logic [1:0]  rsz;
            logic [31:0] ra, rw;
            int          elat;
            rwe = 1'($urandom_range(0, 1));
            rsz = 2'($urandom_range(0, 3));
            run = 1'($urandom_range(0, 1));
            ra  = 32'($urandom_range(0, 63)) | ($urandom & 32'hFFFFF000);
            rw  = $urandom;
            model(rwe, rsz, run, ra, rw, mrd, mmis);
            elat = (mmis || (rwe && rsz == 2'd2)) ? 1 : 2;
            do_req(rwe, rsz, run, ra, rw, lat, rd, mis, rdy1);
            check($sformatf("rnd%0d_lat", n), 32'(lat), 32'(elat));
            check($sformatf("rnd%0d_mis", n), 32'(mis), 32'(mmis));
            if (!rwe || mmis)
                check($sformatf("rnd%0d_rdata", n), rd, mrd);
        end

        repeat (2) @(negedge clk);
        for (int i = 0; i < 16; i++)
            check($sformatf("final_mem%0d", i), mem[i], shadow[i]);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
